// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Latency: none; this is a bundle of signals only.
// Backpressure: byte_ready from the loader gates byte_valid from the source.
// Ports: byte_in/byte_valid/byte_ready (stream), wr_en/wr_addr/wr_data (imem write).
// master = loader side, slave = host source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Loads the instruction memory from a length byte plus big-endian 32-bit words.
// Latency: 4th byte of a word at edge k -> wr_en in cycle k+1; peak 4 bytes per 5 cycles.
// Backpressure: byte_ready is registered and drops during WRITE, IDLE and DONE.
// Ports: clk, reset (async active-low), start, bus (stream in + imem write out),
//        cpu_hold (PC held in reset while loading), done, word_count.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);
    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        COLLECT = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state;
    state_t          next;
    logic [CW-1:0]   total;
    logic [1:0]      byte_idx;
    logic [23:0]     shift;
    logic            byte_ready_q;
    logic            wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]     wr_data_q;
    logic            cpu_hold_q;
    logic            done_q;
    logic [CW-1:0]   word_count_q;

    logic            accept;
    logic [CW-1:0]   wc_next;
    logic [CW-1:0]   len_val;

    // byte_ready is a flop, so accept never forms a path from byte_valid back to byte_ready.
    assign accept  = bus.byte_valid & byte_ready_q;
    assign wc_next = word_count_q + CW'(1);

    // Length 0 means a full memory; anything larger than the memory is clamped.
    always_comb begin
        len_val = CW'(bus.byte_in);
        if (bus.byte_in == 8'd0 || int'(bus.byte_in) > DEPTH) begin
            len_val = CW'(DEPTH);
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = LEN;
            LEN:     if (accept) next = COLLECT;
            COLLECT: if (accept && byte_idx == 2'd3) next = WRITE;
            WRITE:   next = (wc_next == total) ? DONE : COLLECT;
            DONE:    if (start) next = LEN;
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            total        <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state        <= next;
            byte_ready_q <= (next == LEN) || (next == COLLECT);
            wr_en_q      <= (next == WRITE);
            cpu_hold_q   <= (next == LEN) || (next == COLLECT) || (next == WRITE);
            done_q       <= (next == DONE);

            case (state)
                IDLE, DONE: begin
                    if (next == LEN) begin
                        word_count_q <= '0;
                        byte_idx     <= '0;
                        wr_addr_q    <= '0;
                    end
                end
                LEN: begin
                    if (accept) total <= len_val;
                end
                COLLECT: begin
                    if (accept) begin
                        shift    <= {shift[15:0], bus.byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_data_q <= {shift, bus.byte_in};
                            // Words are written in order from 0, so the write address
                            // is the count of words already written; it cannot wrap.
                            wr_addr_q <= word_count_q[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    word_count_q <= wc_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: known streams in, expected writes and status checked.
// Latency: n/a.
// Backpressure: the byte driver holds each byte until byte_ready accepts it.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       done;
    logic [6:0] word_count;

    imem_loader_if #(.ADDR_W(6)) ifc ();

    imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (ifc.master),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write log filled on falling edges, when the registered write port is stable.
    logic [5:0]  log_addr [0:511];
    logic [31:0] log_data [0:511];
    int          n_wr = 0;
    int          n_overlap = 0;

    always @(negedge clk) begin
        if (ifc.wr_en === 1'b1) begin
            if (n_wr < 512) begin
                log_addr[n_wr] = ifc.wr_addr;
                log_data[n_wr] = ifc.wr_data;
            end
            if (ifc.byte_ready === 1'b1) n_overlap++;
            n_wr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a byte at a falling edge and holds it until a rising edge accepts it.
    task automatic send_byte(input logic [7:0] b);
        int waitc = 0;
        ifc.byte_in    = b;
        ifc.byte_valid = 1'b1;
        while (ifc.byte_ready !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 40) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout: byte_ready observed 0 expected 1 (byte 0x%0h)", b);
        end else begin
            @(negedge clk);
        end
        ifc.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] w3;
        logic [7:0]  b3;

        reset          = 1'b1;
        start          = 1'b0;
        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_byte_ready", {31'd0, ifc.byte_ready}, 32'd0);
        chk("rst_wr_en",      {31'd0, ifc.wr_en},      32'd0);
        chk("rst_wr_addr",    {26'd0, ifc.wr_addr},    32'd0);
        chk("rst_wr_data",    ifc.wr_data,             32'd0);
        chk("rst_cpu_hold",   {31'd0, cpu_hold},       32'd0);
        chk("rst_done",       {31'd0, done},           32'd0);
        chk("rst_word_count", {25'd0, word_count},     32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", {31'd0, ifc.byte_ready}, 32'd0);

        // Two words with byte_valid held high
        base = n_wr;
        pulse_start();
        chk("t1_ready_after_start", {31'd0, ifc.byte_ready}, 32'd1);
        chk("t1_hold",              {31'd0, cpu_hold},       32'd1);
        send_byte(8'h02);
        send_word(32'h12345678);
        chk("t1_w0_wr_en",   {31'd0, ifc.wr_en},      32'd1);
        chk("t1_w0_ready",   {31'd0, ifc.byte_ready}, 32'd0);
        chk("t1_w0_addr",    {26'd0, ifc.wr_addr},    32'd0);
        chk("t1_w0_data",    ifc.wr_data,             32'h12345678);
        @(negedge clk);
        chk("t1_ready_back", {31'd0, ifc.byte_ready}, 32'd1);
        chk("t1_wr_en_off",  {31'd0, ifc.wr_en},      32'd0);
        chk("t1_wc_1",       {25'd0, word_count},     32'd1);
        send_word(32'h9ABCDEF0);
        chk("t1_w1_wr_en",   {31'd0, ifc.wr_en},   32'd1);
        chk("t1_w1_addr",    {26'd0, ifc.wr_addr}, 32'd1);
        chk("t1_w1_done0",   {31'd0, done},        32'd0);
        chk("t1_w1_hold1",   {31'd0, cpu_hold},    32'd1);
        @(negedge clk);
        chk("t1_done",       {31'd0, done},           32'd1);
        chk("t1_hold_rel",   {31'd0, cpu_hold},       32'd0);
        chk("t1_wc",         {25'd0, word_count},     32'd2);
        chk("t1_ready_done", {31'd0, ifc.byte_ready}, 32'd0);
        chk("t1_nwr",        n_wr - base,             32'd2);
        chk("t1_log0_addr",  {26'd0, log_addr[base]},   32'd0);
        chk("t1_log0_data",  log_data[base],            32'h12345678);
        chk("t1_log1_addr",  {26'd0, log_addr[base+1]}, 32'd1);
        chk("t1_log1_data",  log_data[base+1],          32'h9ABCDEF0);

        // Length 0 means 64 words
        base = n_wr;
        pulse_start();
        chk("t2_done_clr", {31'd0, done},       32'd0);
        chk("t2_hold",     {31'd0, cpu_hold},   32'd1);
        chk("t2_wc_clr",   {25'd0, word_count}, 32'd0);
        send_byte(8'h00);
        for (int i = 0; i < 64; i++) send_word(32'(i));
        wait_done("t2_done");
        chk("t2_wc", {25'd0, word_count}, 32'd64);
        repeat (5) @(negedge clk);
        chk("t2_nwr", n_wr - base, 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("t2_addr%0d", i), {26'd0, log_addr[base+i]}, 32'(i));
            chk($sformatf("t2_data%0d", i), log_data[base+i],          32'(i));
        end

        // Length 1 with byte_valid toggling; junk bytes while invalid must be ignored
        base = n_wr;
        w3 = 32'hA1B2C3D4;
        pulse_start();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            b3 = w3[(3-i)*8 +: 8];
            ifc.byte_in    = b3;
            ifc.byte_valid = 1'b1;
            @(negedge clk);
            ifc.byte_valid = 1'b0;
            ifc.byte_in    = 8'hFF;
            if (i < 3) @(negedge clk);
        end
        chk("t3_wr_en",  {31'd0, ifc.wr_en},      32'd1);
        chk("t3_ready0", {31'd0, ifc.byte_ready}, 32'd0);
        chk("t3_data",   ifc.wr_data,             32'hA1B2C3D4);
        @(negedge clk);
        chk("t3_done",   {31'd0, done},       32'd1);
        chk("t3_wc",     {25'd0, word_count}, 32'd1);
        chk("t3_nwr",    n_wr - base,         32'd1);
        chk("t3_log",    log_data[base],      32'hA1B2C3D4);

        // start pulsed mid-word is ignored
        base = n_wr;
        pulse_start();
        send_byte(8'h03);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_start();
        chk("t4_done0",  {31'd0, done},           32'd0);
        chk("t4_hold",   {31'd0, cpu_hold},       32'd1);
        chk("t4_wc",     {25'd0, word_count},     32'd1);
        chk("t4_ready",  {31'd0, ifc.byte_ready}, 32'd1);
        send_byte(8'h77);
        send_byte(8'h88);
        send_word(32'hCAFEBABE);
        wait_done("t4_done");
        @(negedge clk);
        chk("t4_nwr",    n_wr - base,                32'd3);
        chk("t4_a1",     {26'd0, log_addr[base+1]},  32'd1);
        chk("t4_d1",     log_data[base+1],           32'h55667788);
        chk("t4_a2",     {26'd0, log_addr[base+2]},  32'd2);
        chk("t4_d2",     log_data[base+2],           32'hCAFEBABE);
        chk("t4_wc3",    {25'd0, word_count},        32'd3);
        pulse_start();
        chk("t4_rs_done0", {31'd0, done},           32'd0);
        chk("t4_rs_hold",  {31'd0, cpu_hold},       32'd1);
        chk("t4_rs_addr0", {26'd0, ifc.wr_addr},    32'd0);
        chk("t4_rs_wc0",   {25'd0, word_count},     32'd0);
        chk("t4_rs_ready", {31'd0, ifc.byte_ready}, 32'd1);

        // Reset during word 3
        base = n_wr;
        send_byte(8'h05);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090A0B0C);
        send_byte(8'hD1);
        send_byte(8'hD2);
        chk("t5_pre_wc",   {25'd0, word_count},  32'd3);
        chk("t5_pre_addr", {26'd0, ifc.wr_addr}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t5_byte_ready", {31'd0, ifc.byte_ready}, 32'd0);
        chk("t5_wr_en",      {31'd0, ifc.wr_en},      32'd0);
        chk("t5_wr_addr",    {26'd0, ifc.wr_addr},    32'd0);
        chk("t5_wr_data",    ifc.wr_data,             32'd0);
        chk("t5_cpu_hold",   {31'd0, cpu_hold},       32'd0);
        chk("t5_done",       {31'd0, done},           32'd0);
        chk("t5_word_count", {25'd0, word_count},     32'd0);
        @(negedge clk);
        reset = 1'b1;
        ifc.byte_in    = 8'h02;
        ifc.byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_idle_nwr",   n_wr - base,             32'd3);
        chk("t5_idle_ready", {31'd0, ifc.byte_ready}, 32'd0);
        chk("t5_idle_hold",  {31'd0, cpu_hold},       32'd0);
        chk("t5_idle_done",  {31'd0, done},           32'd0);
        ifc.byte_valid = 1'b0;

        // Length 0x50 clamped to 64
        base = n_wr;
        pulse_start();
        send_byte(8'h50);
        for (int i = 0; i < 64; i++)
            send_word({i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3});
        wait_done("t6_done");
        chk("t6_wc", {25'd0, word_count}, 32'd64);
        ifc.byte_in    = 8'h77;
        ifc.byte_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_ready0", {31'd0, ifc.byte_ready}, 32'd0);
        chk("t6_done1",  {31'd0, done},           32'd1);
        ifc.byte_valid = 1'b0;
        chk("t6_nwr", n_wr - base, 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("t6_addr%0d", i), {26'd0, log_addr[base+i]}, 32'(i));
            chk($sformatf("t6_data%0d", i), log_data[base+i],
                {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3});
        end

        chk("no_ready_during_write", n_overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream before the core runs. It accepts a length byte followed by 4-byte big-endian instruction words, assembles each word, and writes it to consecutive instruction-memory addresses starting at 0. While loading it holds the program counter in reset, and it releases the counter once the last word is written. It sits between the host byte source and the write port of the 64 x 32 instruction memory read by the program counter.

## Interface
- ADDR_W, 6, instruction-memory address width.
- DEPTH, 64, number of instruction words; equals 2**ADDR_W.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  holds the program counter in reset while high.
- done  output  1  load complete; stays high until the next accepted start or reset.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

## Operation
- Handshake: a byte is accepted on a rising edge where byte_valid and byte_ready are both 1. byte_in is ignored at all other times.
- States: IDLE, LEN, COLLECT, WRITE, DONE.
- IDLE to LEN on start. DONE to LEN on start. Entering LEN clears done, word_count, the byte index and the address, and sets cpu_hold.
- LEN:
  - byte_ready=1.
  - The accepted byte N is the word total; N=0 means DEPTH; N>DEPTH is clamped to DEPTH.
  - Goes to COLLECT.
- COLLECT:
  - byte_ready=1.
  - Accepted bytes shift in MSB first: word = {b0,b1,b2,b3}.
  - The 2-bit byte index increments on each accepted byte.
  - On the 4th accepted byte, goes to WRITE.
- WRITE:
  - Lasts exactly one cycle, with byte_ready=0 and wr_en=1.
  - wr_addr = current address; wr_data = assembled word.
  - word_count increments at the end of the cycle, and the address increments.
  - If word_count reaches N, goes to DONE; otherwise returns to COLLECT.
- DONE: cpu_hold=0, done=1, byte_ready=0.
- start in LEN, COLLECT or WRITE is ignored.
- The address never wraps: at most DEPTH writes per load, addresses 0..N-1.
- byte_valid while byte_ready=0 is not consumed; the source must hold the byte.

## Timing
- Reset values: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, word_count=0.
- Reset mid-load aborts immediately and asynchronously. Partially written memory contents are not cleared.
- Start to byte_ready: start sampled at edge k gives byte_ready=1 during cycle k+1.
- Word latency: 4th byte accepted at edge k gives wr_en=1 during cycle k+1 and byte_ready=1 again in cycle k+2.
- Peak throughput is 4 bytes per 5 cycles.
- wr_addr, wr_data and wr_en are registered outputs, stable for the whole WRITE cycle.
- done rises and cpu_hold falls in the same cycle, the cycle after the final wr_en.
- word_count equals N from that cycle onward.
- All outputs are registered; there is no combinational path from byte_valid to byte_ready.

## Test plan
- Reset then start; stream 02, 12 34 56 78, 9A BC DE F0 with byte_valid held high:
  - wr_en at addr 0 with data 0x12345678, then at addr 1 with data 0x9ABCDEF0.
  - Then done=1, cpu_hold=0, word_count=2.
- Length byte 00, stream 64 words of value i:
  - 64 writes at addrs 0..63.
  - word_count=64, no 65th write, done=1.
- Length 01 with byte_valid toggling 1,0,1,0 across the word bytes:
  - Only handshaked bytes are captured.
  - Single write of the correct word; byte_ready=0 during the WRITE cycle.
- Pulse start during COLLECT:
  - No effect; address and byte index continue.
  - Then start from DONE restarts with addr 0, done=0, cpu_hold=1.
- Assert reset=0 after 2 bytes of word 3:
  - All outputs return to reset values immediately.
  - After release, state is IDLE and no wr_en occurs without a new start.
- Length byte 0x50 (80):
  - Clamped to 64; exactly 64 writes, then DONE.
